spi_host: RTL and testbench



---
 rtl/spi_host.sv | 188 ++++++++++++++++++
 tb/tb_spi_host.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/spi_host.sv
`default_nettype none
// ============================================================================
// Module   : spi_host
// Brief    : Memory-mapped mode-0 SPI master with TX/RX byte FIFOs and RX IRQ
// Revision : 1.0
// ============================================================================
module spi_host #(
    parameter int unsigned FIFO_DEPTH      = 4,
    parameter logic [15:0] DEFAULT_CLK_DIV = 16'd24
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        device_req_i,
    input  logic [31:0] device_addr_i,
    input  logic        device_we_i,
    input  logic [3:0]  device_be_i,
    input  logic [31:0] device_wdata_i,
    output logic        device_rvalid_o,
    output logic [31:0] device_rdata_o,
    output logic        spi_sck_o,
    output logic        spi_cs_no,
    output logic        spi_copi_o,
    input  logic        spi_cipo_i,
    output logic        spi_irq_o
);

    localparam int unsigned c_AW = $clog2(FIFO_DEPTH);
    localparam int unsigned c_PW = c_AW + 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOW  = 2'd1;
    localparam logic [1:0] S_HIGH = 2'd2;

    logic [1:0]      r_state, w_state_nxt;
    logic [7:0]      r_tx_mem [FIFO_DEPTH];
    logic [7:0]      r_rx_mem [FIFO_DEPTH];
    logic [c_PW-1:0] r_tx_wr, r_tx_rd, r_rx_wr, r_rx_rd;
    logic [15:0]     r_clk_div, r_div_cnt;
    logic            r_cs_en, r_irq_en, r_ovf, r_sck, r_irq, r_rvalid;
    logic [7:0]      r_shift, r_rx_sh;
    logic [2:0]      r_bit_cnt;
    logic [31:0]     r_rdata, w_rdata;

    logic w_tx_full, w_tx_empty, w_rx_full, w_rx_empty;
    logic w_sel_tx, w_sel_rx, w_sel_st, w_sel_ctrl, w_rd;
    logic w_tx_push, w_tx_pop, w_rx_push, w_rx_pop;
    logic w_div_hit, w_load, w_sample, w_shift, w_finish;
    logic w_unused;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign w_tx_empty = (r_tx_wr == r_tx_rd);
    assign w_tx_full  = (r_tx_wr[c_AW] != r_tx_rd[c_AW]) &&
                        (r_tx_wr[c_AW-1:0] == r_tx_rd[c_AW-1:0]);
    assign w_rx_empty = (r_rx_wr == r_rx_rd);
    assign w_rx_full  = (r_rx_wr[c_AW] != r_rx_rd[c_AW]) &&
                        (r_rx_wr[c_AW-1:0] == r_rx_rd[c_AW-1:0]);

    assign w_sel_tx   = device_req_i && (device_addr_i[3:2] == 2'd0);
    assign w_sel_rx   = device_req_i && (device_addr_i[3:2] == 2'd1);
    assign w_sel_st   = device_req_i && (device_addr_i[3:2] == 2'd2);
    assign w_sel_ctrl = device_req_i && (device_addr_i[3:2] == 2'd3);
    assign w_rd       = device_req_i && !device_we_i;

    // A same-cycle engine pop frees a slot, so a push into a full FIFO still lands.
    assign w_tx_pop  = w_load;
    assign w_tx_push = w_sel_tx && device_we_i && device_be_i[0] && (!w_tx_full || w_tx_pop);
    assign w_rx_pop  = w_sel_rx && !device_we_i && !w_rx_empty;
    assign w_rx_push = w_finish && (!w_rx_full || w_rx_pop);

    // >= rather than == so a divider lowered below the running count still terminates.
    assign w_div_hit = (r_div_cnt >= r_clk_div);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_state <= S_IDLE;
        else         r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (!w_tx_empty) w_state_nxt = S_LOW;
            S_LOW:   if (w_div_hit)   w_state_nxt = S_HIGH;
            S_HIGH:  if (w_div_hit)   w_state_nxt = (r_bit_cnt == 3'd0) ? S_IDLE : S_LOW;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_load   = (r_state == S_IDLE) && !w_tx_empty;
        w_sample = (r_state == S_LOW)  && w_div_hit;
        w_shift  = (r_state == S_HIGH) && w_div_hit && (r_bit_cnt != 3'd0);
        w_finish = (r_state == S_HIGH) && w_div_hit && (r_bit_cnt == 3'd0);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_shift   <= 8'd0;
            r_rx_sh   <= 8'd0;
            r_bit_cnt <= 3'd0;
            r_div_cnt <= 16'd0;
            r_sck     <= 1'b0;
        end else begin
            if (w_load) begin
                r_shift   <= r_tx_mem[r_tx_rd[c_AW-1:0]];
                r_bit_cnt <= 3'd7;
                r_div_cnt <= 16'd0;
                r_sck     <= 1'b0;
            end else if (r_state != S_IDLE) begin
                r_div_cnt <= w_div_hit ? 16'd0 : r_div_cnt + 16'd1;
            end
            if (w_sample) begin
                r_sck   <= 1'b1;
                r_rx_sh <= {r_rx_sh[6:0], spi_cipo_i};
            end
            if (w_shift) begin
                r_sck     <= 1'b0;
                r_bit_cnt <= r_bit_cnt - 3'd1;
                r_shift   <= {r_shift[6:0], 1'b0};
            end
            if (w_finish) r_sck <= 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_tx_push) r_tx_mem[r_tx_wr[c_AW-1:0]] <= device_wdata_i[7:0];
        if (w_rx_push) r_rx_mem[r_rx_wr[c_AW-1:0]] <= r_rx_sh;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_tx_wr   <= '0;
            r_tx_rd   <= '0;
            r_rx_wr   <= '0;
            r_rx_rd   <= '0;
            r_clk_div <= DEFAULT_CLK_DIV;
            r_cs_en   <= 1'b0;
            r_irq_en  <= 1'b0;
            r_ovf     <= 1'b0;
            r_irq     <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rdata   <= 32'd0;
        end else begin
            if (w_tx_push) r_tx_wr <= r_tx_wr + 1'b1;
            if (w_tx_pop)  r_tx_rd <= r_tx_rd + 1'b1;
            if (w_rx_push) r_rx_wr <= r_rx_wr + 1'b1;
            if (w_rx_pop)  r_rx_rd <= r_rx_rd + 1'b1;
            if (w_sel_ctrl && device_we_i) begin
                if (device_be_i[0]) r_clk_div[7:0]  <= device_wdata_i[7:0];
                if (device_be_i[1]) r_clk_div[15:8] <= device_wdata_i[15:8];
                if (device_be_i[2]) begin
                    r_cs_en  <= device_wdata_i[16];
                    r_irq_en <= device_wdata_i[17];
                end
            end
            // A fresh overflow wins over a clear in the same cycle.
            if (w_finish && !w_rx_push)
                r_ovf <= 1'b1;
            else if (w_sel_st && device_we_i && device_be_i[0] && device_wdata_i[5])
                r_ovf <= 1'b0;
            r_irq    <= r_irq_en && !w_rx_empty;
            r_rvalid <= device_req_i;
            r_rdata  <= w_rd ? w_rdata : 32'd0;
        end
    end

    always_comb begin
        w_rdata = 32'd0;
        case (device_addr_i[3:2])
            2'd1: if (!w_rx_empty) w_rdata = {24'd0, r_rx_mem[r_rx_rd[c_AW-1:0]]};
            2'd2: w_rdata = {26'd0, r_ovf, (r_state != S_IDLE), w_rx_empty, w_rx_full,
                             w_tx_empty, w_tx_full};
            2'd3: w_rdata = {14'd0, r_irq_en, r_cs_en, r_clk_div};
            default: w_rdata = 32'd0;
        endcase
    end

    assign device_rvalid_o = r_rvalid;
    assign device_rdata_o  = r_rdata;
    assign spi_sck_o       = r_sck;
    assign spi_cs_no       = ~r_cs_en;
    assign spi_copi_o      = r_shift[7];
    assign spi_irq_o       = r_irq;

    assign w_unused = ^{device_addr_i[31:4], device_addr_i[1:0], device_wdata_i[31:18],
                        device_be_i[3]};

endmodule
`default_nettype wire

// File: tb/tb_spi_host.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_host
// Brief    : Directed self-checking bench for spi_host (loopback COPI->CIPO)
// Revision : 1.0
// ============================================================================
module tb_spi_host;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req = 1'b0;
    logic [31:0] addr = 32'd0;
    logic        we = 1'b0;
    logic [3:0]  be = 4'd0;
    logic [31:0] wdata = 32'd0;
    logic        rvalid;
    logic [31:0] rdata;
    logic        sck, cs_n, copi, irq;

    int n_tests = 0;
    int n_fail  = 0;

    localparam logic [3:0] A_TX = 4'h0, A_RX = 4'h4, A_ST = 4'h8, A_CTRL = 4'hC;

    always #5 clk = ~clk;

    spi_host dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .device_req_i   (req),
        .device_addr_i  (addr),
        .device_we_i    (we),
        .device_be_i    (be),
        .device_wdata_i (wdata),
        .device_rvalid_o(rvalid),
        .device_rdata_o (rdata),
        .spi_sck_o      (sck),
        .spi_cs_no      (cs_n),
        .spi_copi_o     (copi),
        .spi_cipo_i     (copi),
        .spi_irq_o      (irq)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One bus transaction per clock; called #1 after a rising edge.
    task automatic bus(input logic w, input logic [3:0] a, input logic [31:0] d,
                       input logic [3:0] b, output logic [31:0] r);
        req = 1'b1; we = w; addr = 32'h8000_3000 | {28'd0, a}; wdata = d; be = b;
        @(posedge clk); #1;
        req = 1'b0; we = 1'b0; be = 4'd0;
        check("rvalid", {31'd0, rvalid}, 32'd1);
        r = rdata;
    endtask

    initial begin
        logic [31:0] r;
        int rise_cyc [8];
        logic [7:0] copi_byte;
        int n_rise, idle_at, first_irq;
        logic prev_sck, done;

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset state
        check("rst_cs_n", {31'd0, cs_n}, 32'd1);
        check("rst_sck", {31'd0, sck}, 32'd0);
        check("rst_irq", {31'd0, irq}, 32'd0);
        bus(1'b0, A_ST, 32'd0, 4'd0, r);   check("rst_status", r, 32'h0000_000A);
        bus(1'b0, A_CTRL, 32'd0, 4'd0, r); check("rst_ctrl", r, 32'h0000_0018);

        // Loopback single byte, clk_div=1
        bus(1'b1, A_CTRL, 32'h0001_0001, 4'hF, r);
        check("cs_active", {31'd0, cs_n}, 32'd0);
        bus(1'b1, A_TX, 32'h0000_00A5, 4'h1, r);
        n_rise = 0; idle_at = -1; prev_sck = 1'b0; copi_byte = 8'd0;
        for (int k = 1; k <= 36; k++) begin
            bus(1'b0, A_ST, 32'd0, 4'd0, r);
            if (!prev_sck && sck) begin
                if (n_rise < 8) rise_cyc[n_rise] = k;
                copi_byte = {copi_byte[6:0], copi};
                n_rise++;
            end
            prev_sck = sck;
            if (k > 1 && !r[4] && idle_at < 0) idle_at = k - 1;
        end
        check("sck_rises", n_rise, 8);
        check("first_rise", rise_cyc[0], 3);
        for (int i = 1; i < 8; i++) check("rise_spacing", rise_cyc[i] - rise_cyc[i-1], 4);
        check("copi_bits", {24'd0, copi_byte}, 32'h0000_00A5);
        check("busy_clear", idle_at, 33);
        bus(1'b0, A_RX, 32'd0, 4'd0, r); check("rx_a5", r, 32'h0000_00A5);
        bus(1'b0, A_RX, 32'd0, 4'd0, r); check("rx_empty_read", r, 32'd0);

        // TX FIFO full, RX overflow (clk_div=100)
        bus(1'b1, A_CTRL, 32'h0001_0064, 4'hF, r);
        for (int i = 1; i <= 6; i++) bus(1'b1, A_TX, i, 4'h1, r);
        done = 1'b0;
        for (int i = 0; i < 20000 && !done; i++) begin
            bus(1'b0, A_ST, 32'd0, 4'd0, r);
            if (!r[4] && r[1]) done = 1'b1;
        end
        check("drain_done", {31'd0, done}, 32'd1);
        bus(1'b0, A_ST, 32'd0, 4'd0, r); check("status_ovf", r, 32'h0000_0026);
        bus(1'b1, A_ST, 32'h0000_0020, 4'h1, r);
        bus(1'b0, A_ST, 32'd0, 4'd0, r); check("status_ovf_clr", r, 32'h0000_0006);
        for (int i = 1; i <= 4; i++) begin
            bus(1'b0, A_RX, 32'd0, 4'd0, r); check("rx_seq", r, i);
        end
        bus(1'b0, A_ST, 32'd0, 4'd0, r); check("status_drained", r, 32'h0000_000A);

        // IRQ
        bus(1'b1, A_CTRL, 32'h0003_0001, 4'hF, r);
        bus(1'b1, A_TX, 32'h0000_003C, 4'h1, r);
        first_irq = -1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (irq && first_irq < 0) first_irq = k;
        end
        check("irq_rise", first_irq, 34);
        bus(1'b0, A_RX, 32'd0, 4'd0, r); check("irq_rx", r, 32'h0000_003C);
        check("irq_lag", {31'd0, irq}, 32'd1);
        @(posedge clk); #1;
        check("irq_fall", {31'd0, irq}, 32'd0);

        // Reset during bit 3 of 0xFF
        bus(1'b1, A_CTRL, 32'h0001_0001, 4'hF, r);
        bus(1'b1, A_TX, 32'h0000_00FF, 4'h1, r);
        repeat (20) @(posedge clk);
        #1;
        check("mid_sck", {31'd0, sck}, 32'd1);
        check("mid_copi", {31'd0, copi}, 32'd1);
        check("mid_cs_n", {31'd0, cs_n}, 32'd0);
        #1 rst_n = 1'b0;
        #1;
        check("arst_sck", {31'd0, sck}, 32'd0);
        check("arst_copi", {31'd0, copi}, 32'd0);
        check("arst_cs_n", {31'd0, cs_n}, 32'd1);
        check("arst_irq", {31'd0, irq}, 32'd0);
        check("arst_rvalid", {31'd0, rvalid}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        bus(1'b0, A_ST, 32'd0, 4'd0, r);   check("post_status", r, 32'h0000_000A);
        bus(1'b0, A_RX, 32'd0, 4'd0, r);   check("post_rx", r, 32'd0);
        bus(1'b0, A_CTRL, 32'd0, 4'd0, r); check("post_ctrl", r, 32'h0000_0018);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
